// File: rtl/q_learn_pkg.sv
// Shared types and constants for the Q-learning update datapath.
// All Q values are signed Q15.16.
package q_learn_pkg;

    localparam int unsigned N_STATES  = 37;
    localparam int unsigned N_ACTIONS = 4;

    typedef logic signed [31:0] q_t;
    typedef q_t [N_STATES-1:0][N_ACTIONS-1:0] q_table_t;

    localparam q_t ALPHA_Q = 32'sh0000_3333;
    localparam q_t GAMMA_Q = 32'sh0000_E666;

    typedef enum logic [2:0] {
        IDLE,
        MUL_DISC,
        SUB,
        MUL_ALPHA,
        WRITE
    } q_state_e;

    // Q31.32 product back to Q15.16: bits [47:16], i.e. truncation toward -inf.
    function automatic q_t trim_q16(input logic signed [63:0] p);
        return q_t'(p >>> 16);
    endfunction

endpackage

// File: rtl/q_value_update_fx_mul.sv
// Signed Q15.16 x Q15.16 multiplier producing the full Q31.32 product.
module fx_mul_q16
    import q_learn_pkg::*;
(
    input  q_t                 a_i,
    input  q_t                 b_i,
    output logic signed [63:0] prod_o
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;

    assign a_ext  = 64'(a_i);
    assign b_ext  = 64'(b_i);
    assign prod_o = a_ext * b_ext;

endmodule

// File: rtl/q_value_update.sv
// One Q-learning table update: Qnew = Qold + ALPHA*(R + GAMMA*maxQ - Qold),
// sequenced over IDLE -> MUL_DISC -> SUB -> MUL_ALPHA -> WRITE.
module q_value_update
    import q_learn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  q_table_t    old_Q,
    input  logic [5:0]  maze_state,
    input  logic [3:0]  action,
    input  q_t          max_Q,
    input  logic [3:0]  reward,
    output q_table_t    new_Q,
    output logic        done_o
);

    q_state_e           state_q;
    q_t                 old_sel_d;
    q_t                 old_sel_q;
    q_t                 max_q_q;
    logic [3:0]         reward_q;
    logic [5:0]         st_idx_q;
    logic [3:0]         act_idx_q;
    logic signed [63:0] disc_x_max_q;
    q_t                 reward_shift_q;
    q_t                 min_Q_F_q;
    logic signed [63:0] x_learn_q;
    q_table_t           new_Q_q;
    logic               done_q;

    q_t                 mul_a;
    q_t                 mul_b;
    logic signed [63:0] mul_p;

    // Out-of-range indices match no entry, so the selected value falls back to 0.
    always_comb begin
        old_sel_d = '0;
        for (int unsigned i = 0; i < N_STATES; i++) begin
            for (int unsigned j = 0; j < N_ACTIONS; j++) begin
                if (maze_state == 6'(i) && action == 4'(j)) begin
                    old_sel_d = old_Q[i][j];
                end
            end
        end
    end

    // One multiplier shared by the two MUL states.
    always_comb begin
        mul_a = ALPHA_Q;
        mul_b = min_Q_F_q;
        if (state_q == MUL_DISC) begin
            mul_a = GAMMA_Q;
            mul_b = max_q_q;
        end
    end

    fx_mul_q16 u_mul (
        .a_i    (mul_a),
        .b_i    (mul_b),
        .prod_o (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            old_sel_q      <= '0;
            max_q_q        <= '0;
            reward_q       <= '0;
            st_idx_q       <= '0;
            act_idx_q      <= '0;
            disc_x_max_q   <= '0;
            reward_shift_q <= '0;
            min_Q_F_q      <= '0;
            x_learn_q      <= '0;
            new_Q_q        <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (done) begin
                        old_sel_q <= old_sel_d;
                        max_q_q   <= max_Q;
                        reward_q  <= reward;
                        st_idx_q  <= maze_state;
                        act_idx_q <= action;
                        state_q   <= MUL_DISC;
                    end
                end
                MUL_DISC: begin
                    disc_x_max_q   <= mul_p;
                    reward_shift_q <= q_t'({12'd0, reward_q, 16'd0});
                    state_q        <= SUB;
                end
                SUB: begin
                    min_Q_F_q <= trim_q16(disc_x_max_q) + reward_shift_q - old_sel_q;
                    state_q   <= MUL_ALPHA;
                end
                MUL_ALPHA: begin
                    x_learn_q <= mul_p;
                    state_q   <= WRITE;
                end
                WRITE: begin
                    for (int unsigned i = 0; i < N_STATES; i++) begin
                        for (int unsigned j = 0; j < N_ACTIONS; j++) begin
                            if (st_idx_q == 6'(i) && act_idx_q == 4'(j)) begin
                                new_Q_q[i][j] <= old_sel_q + trim_q16(x_learn_q);
                            end else begin
                                new_Q_q[i][j] <= old_Q[i][j];
                            end
                        end
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign new_Q  = new_Q_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_q_value_update.sv
// Scoreboard bench for q_value_update: directed vectors with hand-computed Q15.16 results.
module tb_q_value_update;
    import q_learn_pkg::*;

    typedef struct {
        q_table_t tbl;
        int       cyc;
        int       id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    q_table_t   tbl;
    logic [5:0] st_in;
    logic [3:0] act_in;
    logic [3:0] rew_in;
    q_t         max_in;
    q_table_t   new_Q;
    logic       done_o;

    exp_t       sb[$];
    exp_t       e;
    q_table_t   last_exp;
    q_table_t   hold_tbl;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic       chk_zero = 1'b0;
    logic       chk_hold = 1'b0;
    logic       timeout_flag = 1'b0;
    logic       chk_final = 1'b0;
    logic       prev_done = 1'b0;

    q_value_update dut (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .old_Q      (tbl),
        .maze_state (st_in),
        .action     (act_in),
        .max_Q      (max_in),
        .reward     (rew_in),
        .new_Q      (new_Q),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string first_diff(input q_table_t got, input q_table_t want);
        for (int i = 0; i < int'(N_STATES); i++) begin
            for (int j = 0; j < int'(N_ACTIONS); j++) begin
                if (got[i][j] !== want[i][j])
                    return $sformatf("entry[%0d][%0d] got=%h exp=%h", i, j, got[i][j], want[i][j]);
            end
        end
        return "no differing entry";
    endfunction

    // Monitor: owns all counters; the driver only raises request flags.
    always @(negedge clk) begin
        if (done_o) begin
            checks++;
            if (prev_done) begin
                failures++;
                $display("FAIL pulse_width done_o high two cycles running got=1 exp=0");
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done cycle=%0d got=1 exp=0", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL latency id=%0d got_cycle=%0d exp_cycle=%0d", e.id, cyc, e.cyc);
                end
                checks++;
                if (new_Q !== e.tbl) begin
                    failures++;
                    $display("FAIL table id=%0d %s", e.id, first_diff(new_Q, e.tbl));
                end
            end
        end
        prev_done <= done_o;
        if (chk_zero) begin
            checks++;
            if (new_Q !== '0 || done_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_state done_o got=%b exp=0 %s", done_o, first_diff(new_Q, '0));
            end
        end
        if (chk_hold) begin
            checks++;
            if (new_Q !== hold_tbl) begin
                failures++;
                $display("FAIL hold %s", first_diff(new_Q, hold_tbl));
            end
        end
        if (timeout_flag) begin
            checks++;
            failures++;
            $display("FAIL timeout done_o got=0 exp=1 within budget");
        end
        if (chk_final) begin
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL drain pending got=%0d exp=0", sb.size());
            end
        end
    end

    task automatic run_op(input q_t oldv, input q_t maxv, input logic [5:0] st,
                          input logic [3:0] act, input logic [3:0] rew,
                          input q_t expv, input int id, input int nops);
        exp_t ex;
        int   c;
        st_in  = st;
        act_in = act;
        rew_in = rew;
        max_in = maxv;
        if (st < 6'd37 && act < 4'd4) tbl[int'(st)][int'(act)] = oldv;
        ex.tbl = tbl;
        if (st < 6'd37 && act < 4'd4) ex.tbl[int'(st)][int'(act)] = expv;
        ex.id  = id;
        done   = 1'b1;
        c      = cyc;
        for (int k = 0; k < nops; k++) begin
            ex.cyc = c + 5 + 5 * k;
            sb.push_back(ex);
        end
        last_exp = ex.tbl;
        repeat (5 * (nops - 1) + 1) @(posedge clk);
        #2 done = 1'b0;
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            timeout_flag = 1'b1;
            sb.delete();
            @(posedge clk);
            #2 timeout_flag = 1'b0;
        end
    endtask

    initial begin
        rst    = 1'b1;
        done   = 1'b0;
        st_in  = '0;
        act_in = '0;
        rew_in = '0;
        max_in = '0;
        for (int i = 0; i < int'(N_STATES); i++)
            for (int j = 0; j < int'(N_ACTIONS); j++)
                tbl[i][j] = q_t'((i * 4 + j) * 70001) - q_t'(5000000);

        repeat (2) @(posedge clk);
        #2 chk_zero = 1'b1;
        @(posedge clk);
        #2 chk_zero = 1'b0;
        rst = 1'b0;

        // 6.9 / 5.0: disc_trim 294910, +reward 10 -> 551729 (8.42), reward 0 -> 420659 (6.42)
        run_op(32'h0006E600, 32'h00050000, 6'd5, 4'd2, 4'd10, 32'sd551729, 1, 1);

        hold_tbl = last_exp;
        tbl[10][1] = tbl[10][1] + 1;
        chk_hold = 1'b1;
        repeat (2) @(posedge clk);
        #2 chk_hold = 1'b0;

        run_op(32'h0006E600, 32'h00050000, 6'd5, 4'd2, 4'd0, 32'sd420659, 2, 1);
        // 4.3 / 5.5 at the last table entry
        run_op(32'h00044CCD, 32'h00058000, 6'd36, 4'd3, 4'd10, 32'sd421394, 3, 1);
        run_op(32'h00044CCD, 32'h00058000, 6'd36, 4'd3, 4'd0, 32'sd290324, 4, 1);
        // 5.5 / 4.3 at the first entry; reward 0 gives a negative min_Q
        run_op(32'h00058000, 32'h00044CCD, 6'd0, 4'd0, 4'd10, 32'sd470153, 5, 1);
        run_op(32'h00058000, 32'h00044CCD, 6'd0, 4'd0, 4'd0, 32'sd339083, 6, 2);
        // Out-of-range indices leave the table untouched
        run_op(32'h12345678, 32'h00050000, 6'd40, 4'd1, 4'd10, 32'sd0, 7, 1);
        run_op(32'h12345678, 32'h00050000, 6'd3, 4'd7, 4'd10, 32'sd0, 8, 1);

        // Reset while in MUL_ALPHA discards the operation
        st_in  = 6'd5;
        act_in = 4'd2;
        rew_in = 4'd10;
        max_in = 32'h00050000;
        done   = 1'b1;
        @(posedge clk);
        #2 done = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        chk_zero = 1'b1;
        @(posedge clk);
        #2 chk_zero = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        run_op(32'h0006E600, 32'h00050000, 6'd5, 4'd2, 4'd10, 32'sd551729, 9, 1);

        chk_final = 1'b1;
        @(posedge clk);
        #2 chk_final = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
